// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: accepts one byte per valid/ready handshake and
// serialises it (start, 8 data LSB first, optional parity, 1-2 stop bits).
module uart_tx_sequencer #(
   parameter int unsigned BAUD_DIV  = 9600,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic       iClk,
   input  logic       iReset,
   input  logic [7:0] iData,
   input  logic       iValid,
   output logic       oReady,
   output logic       oTx,
   output logic       oBusy,
   output logic       oBaudTick
);

   localparam int unsigned CNT_W  = 14;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned DATA_W = 8;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

   // Elaboration-time guards on the parameter set
   if (BAUD_DIV < 2 || BAUD_DIV > 16383) begin : g_bad_baud_div
      $error("uart_tx_sequencer: BAUD_DIV out of range 2..16383");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_sequencer: STOP_BITS must be 1 or 2");
   end
   if (PARITY > 2) begin : g_bad_parity
      $error("uart_tx_sequencer: PARITY must be 0, 1 or 2");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [IDX_W-1:0]    r_bit_idx;
   logic [DATA_W-1:0]   r_shift;
   logic                r_parity;
   logic                r_stop_idx;
   logic                r_tx;
   logic                r_ready;
   logic                r_busy;
   logic                r_tick;

   state_t              w_state_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [IDX_W-1:0]    w_bit_idx_nxt;
   logic [DATA_W-1:0]   w_shift_nxt;
   logic                w_parity_nxt;
   logic                w_stop_idx_nxt;
   logic                w_tx_nxt;
   logic                w_ready_nxt;
   logic                w_busy_nxt;
   logic                w_tick_nxt;
   logic                w_accept;
   logic                w_tick;

   assign w_accept = iValid & r_ready;
   assign w_tick   = (r_state != ST_IDLE) && (r_cnt == CNT_LAST);

   // State and datapath registers
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_parity   <= 1'b0;
         r_stop_idx <= 1'b0;
         r_tx       <= 1'b1;
         r_ready    <= 1'b1;
         r_busy     <= 1'b0;
         r_tick     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_bit_idx  <= w_bit_idx_nxt;
         r_shift    <= w_shift_nxt;
         r_parity   <= w_parity_nxt;
         r_stop_idx <= w_stop_idx_nxt;
         r_tx       <= w_tx_nxt;
         r_ready    <= w_ready_nxt;
         r_busy     <= w_busy_nxt;
         r_tick     <= w_tick_nxt;
      end
   end

   // Next-state, divider and line-level logic
   always_comb begin
      w_state_nxt    = r_state;
      w_bit_idx_nxt  = r_bit_idx;
      w_shift_nxt    = r_shift;
      w_parity_nxt   = r_parity;
      w_stop_idx_nxt = r_stop_idx;
      w_tx_nxt       = r_tx;

      if (r_state == ST_IDLE || w_tick) begin
         w_cnt_nxt = '0;
      end else begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end

      case (r_state)
         ST_IDLE: begin
            w_tx_nxt = 1'b1;
            if (w_accept) begin
               w_shift_nxt    = iData;
               w_parity_nxt   = (PARITY == 2) ? ~(^iData) : (^iData);
               w_bit_idx_nxt  = '0;
               w_stop_idx_nxt = 1'b0;
               w_tx_nxt       = 1'b0;
               w_state_nxt    = ST_START;
            end
         end
         ST_START: begin
            if (w_tick) begin
               w_tx_nxt      = r_shift[0];
               w_shift_nxt   = {1'b0, r_shift[DATA_W-1:1]};
               w_bit_idx_nxt = '0;
               w_state_nxt   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_tick) begin
               if (r_bit_idx == IDX_LAST) begin
                  w_stop_idx_nxt = 1'b0;
                  if (PARITY != 0) begin
                     w_tx_nxt    = r_parity;
                     w_state_nxt = ST_PARITY;
                  end else begin
                     w_tx_nxt    = 1'b1;
                     w_state_nxt = ST_STOP;
                  end
               end else begin
                  w_tx_nxt      = r_shift[0];
                  w_shift_nxt   = {1'b0, r_shift[DATA_W-1:1]};
                  w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
               end
            end
         end
         ST_PARITY: begin
            if (w_tick) begin
               w_tx_nxt       = 1'b1;
               w_stop_idx_nxt = 1'b0;
               w_state_nxt    = ST_STOP;
            end
         end
         ST_STOP: begin
            w_tx_nxt = 1'b1;
            if (w_tick) begin
               if (r_stop_idx == STOP_LAST) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_stop_idx_nxt = 1'b1;
               end
            end
         end
         default: begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Status and tick are registered from the next state so they line up
      // with the state register in the same cycle.
      w_ready_nxt = (w_state_nxt == ST_IDLE);
      w_busy_nxt  = (w_state_nxt != ST_IDLE);
      w_tick_nxt  = (w_state_nxt != ST_IDLE) && (w_cnt_nxt == CNT_LAST);
   end

   assign oReady    = r_ready;
   assign oTx       = r_tx;
   assign oBusy     = r_busy;
   assign oBaudTick = r_tick;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer: four instances with different
// parity/stop configurations, a per-instance line monitor decodes frames.
module tb_uart_tx_sequencer;

   typedef struct packed {
      logic [11:0] bits;   // transmission order, bits[0] = start bit
      logic [3:0]  len;    // number of bit periods in the frame
   } frame_t;

   logic       clk;
   logic       rst   [4];
   logic [7:0] data  [4];
   logic       valid [4];
   logic       ready [4];
   logic       tx    [4];
   logic       busy  [4];
   logic       tick  [4];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_start [4];
   int prev_start [4];

   frame_t q0[$];
   frame_t q1[$];
   frame_t q2[$];
   frame_t q3[$];

   uart_tx_sequencer #(.BAUD_DIV(4), .PARITY(0), .STOP_BITS(1)) u_dut0 (
      .iClk(clk), .iReset(rst[0]), .iData(data[0]), .iValid(valid[0]),
      .oReady(ready[0]), .oTx(tx[0]), .oBusy(busy[0]), .oBaudTick(tick[0]));
   uart_tx_sequencer #(.BAUD_DIV(4), .PARITY(1), .STOP_BITS(1)) u_dut1 (
      .iClk(clk), .iReset(rst[1]), .iData(data[1]), .iValid(valid[1]),
      .oReady(ready[1]), .oTx(tx[1]), .oBusy(busy[1]), .oBaudTick(tick[1]));
   uart_tx_sequencer #(.BAUD_DIV(4), .PARITY(2), .STOP_BITS(1)) u_dut2 (
      .iClk(clk), .iReset(rst[2]), .iData(data[2]), .iValid(valid[2]),
      .oReady(ready[2]), .oTx(tx[2]), .oBusy(busy[2]), .oBaudTick(tick[2]));
   uart_tx_sequencer #(.BAUD_DIV(4), .PARITY(0), .STOP_BITS(2)) u_dut3 (
      .iClk(clk), .iReset(rst[3]), .iData(data[3]), .iValid(valid[3]),
      .oReady(ready[3]), .oTx(tx[3]), .oBusy(busy[3]), .oBaudTick(tick[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int qsize(input int k);
      case (k)
         0: return q0.size();
         1: return q1.size();
         2: return q2.size();
         default: return q3.size();
      endcase
   endfunction

   task automatic qpush(input int k, input frame_t f);
      case (k)
         0: q0.push_back(f);
         1: q1.push_back(f);
         2: q2.push_back(f);
         default: q3.push_back(f);
      endcase
   endtask

   task automatic qpop(input int k, output frame_t f);
      case (k)
         0: f = q0.pop_front();
         1: f = q1.pop_front();
         2: f = q2.pop_front();
         default: f = q3.pop_front();
      endcase
   endtask

   // Line monitor: detects a start edge, pops the expected frame and checks
   // every sample of every bit period plus end-of-frame status and tick count.
   task automatic mon(input int k);
      logic   prev;
      frame_t e;
      bit     ab;
      bit     bit_ok;
      int     ticks;
      int     j;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (rst[k]) begin
            prev = 1'b1;
            continue;
         end
         if (prev && !tx[k]) begin
            chk($sformatf("u%0d_frame_expected", k), 32'(qsize(k) != 0), 32'd1);
            if (qsize(k) != 0) begin
               qpop(k, e);
               prev_start[k] = last_start[k];
               last_start[k] = cyc;
               ticks  = 0;
               ab     = 1'b0;
               bit_ok = 1'b1;
               for (int n = 0; n < 4 * int'(e.len); n++) begin
                  if (n != 0) @(negedge clk);
                  if (rst[k]) begin
                     ab = 1'b1;
                     break;
                  end
                  j = n / 4;
                  if (tx[k] !== e.bits[j]) bit_ok = 1'b0;
                  if (tick[k]) ticks++;
                  if (n % 4 == 3) begin
                     chk($sformatf("u%0d_bit%0d", k, j),
                         32'(bit_ok ? e.bits[j] : ~e.bits[j]), 32'(e.bits[j]));
                     bit_ok = 1'b1;
                  end
                  if (n == 4 * int'(e.len) - 1)
                     chk($sformatf("u%0d_ready_before_end", k), 32'(ready[k]), 32'd0);
               end
               if (ab) begin
                  prev = 1'b1;
                  continue;
               end
               @(negedge clk);
               chk($sformatf("u%0d_ready_at_end", k), 32'(ready[k]), 32'd1);
               chk($sformatf("u%0d_busy_at_end", k), 32'(busy[k]), 32'd0);
               chk($sformatf("u%0d_tick_count", k), 32'(ticks), 32'(e.len));
            end
         end
         prev = tx[k];
      end
   endtask

   initial mon(0);
   initial mon(1);
   initial mon(2);
   initial mon(3);

   task automatic wait_ready_lvl(input int k, input logic lvl);
      int n;
      n = 0;
      while (ready[k] !== lvl && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) chk($sformatf("u%0d_ready_wait_timeout", k), 32'(ready[k]), 32'(lvl));
   endtask

   // Issues one byte at a negedge while ready; returns at the negedge after accept.
   task automatic send(input int k, input logic [7:0] d, input logic [11:0] bits,
                       input logic [3:0] len);
      frame_t f;
      wait_ready_lvl(k, 1'b1);
      f.bits = bits;
      f.len  = len;
      qpush(k, f);
      data[k]  = d;
      valid[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid[k] = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int idle_tx_bad;
      int idle_ticks;
      for (int k = 0; k < 4; k++) begin
         rst[k] = 1'b1; valid[k] = 1'b0; data[k] = 8'h00;
         last_start[k] = 0; prev_start[k] = 0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("u%0d_reset_tx", k), 32'(tx[k]), 32'd1);
         chk($sformatf("u%0d_reset_ready", k), 32'(ready[k]), 32'd1);
      end
      chk("u0_reset_busy", 32'(busy[0]), 32'd0);
      chk("u0_reset_tick", 32'(tick[0]), 32'd0);
      for (int k = 0; k < 4; k++) rst[k] = 1'b0;

      // Mid-cycle reset then idle for 50 cycles
      @(posedge clk);
      #3 rst[0] = 1'b1;
      #1;
      chk("u0_midcycle_rst_tx", 32'(tx[0]), 32'd1);
      chk("u0_midcycle_rst_ready", 32'(ready[0]), 32'd1);
      chk("u0_midcycle_rst_busy", 32'(busy[0]), 32'd0);
      @(negedge clk);
      rst[0] = 1'b0;
      idle_tx_bad = 0;
      idle_ticks  = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tx[0] !== 1'b1) idle_tx_bad++;
         if (tick[0] !== 1'b0) idle_ticks++;
      end
      chk("u0_idle_tx_low_samples", 32'(idle_tx_bad), 32'd0);
      chk("u0_idle_tick_pulses", 32'(idle_ticks), 32'd0);

      // Single frames: 0xA5 no parity, even, odd; 0x07 even
      send(0, 8'hA5, 12'b00_1_10100101_0, 4'd10);
      send(1, 8'hA5, 12'b0_1_0_10100101_0, 4'd11);
      send(2, 8'hA5, 12'b0_1_1_10100101_0, 4'd11);
      send(1, 8'h07, 12'b0_1_1_00000111_0, 4'd11);
      wait_ready_lvl(0, 1'b1);
      wait_ready_lvl(1, 1'b1);
      wait_ready_lvl(2, 1'b1);
      repeat (2) @(negedge clk);

      // Back-to-back with two stop bits, iValid held, iData changed mid-frame
      wait_ready_lvl(3, 1'b1);
      qpush(3, '{bits: 12'b0_11_01010101_0, len: 4'd11});
      qpush(3, '{bits: 12'b0_11_00001111_0, len: 4'd11});
      data[3]  = 8'h55;
      valid[3] = 1'b1;
      @(posedge clk);
      #1 data[3] = 8'h0F;
      @(negedge clk);
      wait_ready_lvl(3, 1'b1);
      wait_ready_lvl(3, 1'b0);
      data[3]  = 8'h99;
      valid[3] = 1'b0;
      wait_ready_lvl(3, 1'b1);
      repeat (2) @(negedge clk);
      chk("u3_back_to_back_gap", 32'(last_start[3] - prev_start[3]), 32'd45);

      // Request during DATA of a 0x00 frame is ignored
      send(0, 8'h00, 12'b00_1_00000000_0, 4'd10);
      repeat (12) @(negedge clk);
      data[0]  = 8'hFF;
      valid[0] = 1'b1;
      @(negedge clk);
      valid[0] = 1'b0;
      wait_ready_lvl(0, 1'b1);
      repeat (60) @(negedge clk);
      chk("u0_no_second_frame_busy", 32'(busy[0]), 32'd0);
      chk("u0_queue_drained", 32'(qsize(0)), 32'd0);

      // Reset during data bit 3, then a clean 0x3C frame
      send(0, 8'h52, 12'b00_1_01010010_0, 4'd10);
      repeat (17) @(negedge clk);
      chk("u0_pre_reset_bit3", 32'(tx[0]), 32'd0);
      #1 rst[0] = 1'b1;
      #1;
      chk("u0_async_reset_tx", 32'(tx[0]), 32'd1);
      chk("u0_async_reset_ready", 32'(ready[0]), 32'd1);
      chk("u0_async_reset_busy", 32'(busy[0]), 32'd0);
      repeat (2) @(negedge clk);
      rst[0] = 1'b0;
      send(0, 8'h3C, 12'b00_1_00111100_0, 4'd10);
      wait_ready_lvl(0, 1'b1);
      repeat (3) @(negedge clk);

      for (int k = 0; k < 4; k++)
         chk($sformatf("u%0d_scoreboard_empty", k), 32'(qsize(k)), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
